control: RTL and testbench

- Main decoder for the 32-bit MIPS core. Maps the 6-bit `Opcode` and 6-bit `funct` fields of the current instruction to datapath control strobes and a 6-bit ALU operation code.
- Outputs are registered: they launch one clock after the instruction fields are presented, in step with the pipelined datapath.

---
 rtl/mips_pkg.sv | 71 +++++++
 rtl/control_if.sv | 37 +++
 rtl/control_decode.sv | 87 ++++++++
 rtl/control.sv | 61 ++++++
 tb/tb_control.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Opcode, funct and ALU-operation encodings shared by the MIPS control path.
// Also defines the control-vector struct carried between decoder and output register.
package mips_pkg;

    typedef enum logic [5:0] {
        ALU_NOP   = 6'd0,
        ALU_ADD   = 6'd1,
        ALU_ADDU  = 6'd2,
        ALU_SUB   = 6'd3,
        ALU_SUBU  = 6'd4,
        ALU_AND   = 6'd5,
        ALU_OR    = 6'd6,
        ALU_XOR   = 6'd7,
        ALU_NOR   = 6'd8,
        ALU_SLT   = 6'd9,
        ALU_SLTU  = 6'd10,
        ALU_SLL   = 6'd11,
        ALU_SRL   = 6'd12,
        ALU_SRA   = 6'd13,
        ALU_LUI   = 6'd14,
        ALU_SUBNE = 6'd15
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef struct packed {
        logic    dst_reg;
        logic    alu_src_b;
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_write;
        logic    jump;
        logic    branch;
        logic    shamt_flag;
        logic    jump_reg;
        alu_op_e alu_op;
    } ctrl_t;

endpackage

// File: rtl/control_if.sv
// Instruction-field / control-strobe bundle between the datapath (master) and control (slave).
// IllegalOp exists only when CONTROL_ILLEGAL_OP_EN is defined.
interface control_if;
    logic [5:0] Opcode;
    logic [5:0] funct;
    logic       DstReg;
    logic       ALUSrcB;
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic       shamtFlag;
    logic       JumpReg;
    logic [5:0] ALUOp;
`ifdef CONTROL_ILLEGAL_OP_EN
    logic       IllegalOp;
`endif

    modport master (
`ifdef CONTROL_ILLEGAL_OP_EN
        input  IllegalOp,
`endif
        output Opcode, funct,
        input  DstReg, ALUSrcB, RegWrite, MemtoReg, MemWrite,
        input  Jump, Branch, shamtFlag, JumpReg, ALUOp
    );

    modport slave (
`ifdef CONTROL_ILLEGAL_OP_EN
        output IllegalOp,
`endif
        input  Opcode, funct,
        output DstReg, ALUSrcB, RegWrite, MemtoReg, MemWrite,
        output Jump, Branch, shamtFlag, JumpReg, ALUOp
    );
endinterface

// File: rtl/control_decode.sv
// Purely combinational Opcode/funct -> control vector decoder.
// Illegal-encoding flag output present only under CONTROL_ILLEGAL_OP_EN.
module control_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
`ifdef CONTROL_ILLEGAL_OP_EN
    output logic       illegal_o,
`endif
    output ctrl_t      ctrl_o
);

    logic illegal_s;

    // Main decode; anything unrecognised collapses to the all-zero vector.
    always_comb begin
        ctrl_o    = '0;
        illegal_s = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.dst_reg   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                case (funct_i)
                    FN_ADD:  ctrl_o.alu_op = ALU_ADD;
                    FN_ADDU: ctrl_o.alu_op = ALU_ADDU;
                    FN_SUB:  ctrl_o.alu_op = ALU_SUB;
                    FN_SUBU: ctrl_o.alu_op = ALU_SUBU;
                    FN_AND:  ctrl_o.alu_op = ALU_AND;
                    FN_OR:   ctrl_o.alu_op = ALU_OR;
                    FN_XOR:  ctrl_o.alu_op = ALU_XOR;
                    FN_NOR:  ctrl_o.alu_op = ALU_NOR;
                    FN_SLT:  ctrl_o.alu_op = ALU_SLT;
                    FN_SLTU: ctrl_o.alu_op = ALU_SLTU;
                    FN_SLL:  begin ctrl_o.alu_op = ALU_SLL; ctrl_o.shamt_flag = 1'b1; end
                    FN_SRL:  begin ctrl_o.alu_op = ALU_SRL; ctrl_o.shamt_flag = 1'b1; end
                    FN_SRA:  begin ctrl_o.alu_op = ALU_SRA; ctrl_o.shamt_flag = 1'b1; end
                    FN_SLLV: ctrl_o.alu_op = ALU_SLL;
                    FN_SRLV: ctrl_o.alu_op = ALU_SRL;
                    FN_SRAV: ctrl_o.alu_op = ALU_SRA;
                    FN_JR: begin
                        ctrl_o.dst_reg   = 1'b0;
                        ctrl_o.reg_write = 1'b0;
                        ctrl_o.jump_reg  = 1'b1;
                    end
                    default: begin
                        ctrl_o    = '0;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            OP_ADDI:  begin ctrl_o.alu_src_b = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_ADD;  end
            OP_ADDIU: begin ctrl_o.alu_src_b = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_ADDU; end
            OP_ANDI:  begin ctrl_o.alu_src_b = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_AND;  end
            OP_ORI:   begin ctrl_o.alu_src_b = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_OR;   end
            OP_XORI:  begin ctrl_o.alu_src_b = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_XOR;  end
            OP_LUI:   begin ctrl_o.alu_src_b = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_LUI;  end
            OP_SLTI:  begin ctrl_o.alu_src_b = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_SLT;  end
            OP_SLTIU: begin ctrl_o.alu_src_b = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_SLTU; end
            OP_LW: begin
                ctrl_o.alu_src_b  = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin ctrl_o.branch = 1'b1; ctrl_o.alu_op = ALU_SUB;   end
            OP_BNE: begin ctrl_o.branch = 1'b1; ctrl_o.alu_op = ALU_SUBNE; end
            OP_J:   ctrl_o.jump = 1'b1;
            // jal writes $31; the datapath forces that destination from Jump&RegWrite.
            OP_JAL: begin ctrl_o.jump = 1'b1; ctrl_o.reg_write = 1'b1; end
            default: illegal_s = 1'b1;
        endcase
    end

`ifdef CONTROL_ILLEGAL_OP_EN
    assign illegal_o = illegal_s;
`else
    logic unused_s;
    assign unused_s = illegal_s;
`endif

endmodule

// File: rtl/control.sv
// MIPS main control: combinational decode followed by an async-reset output register.
// Define CONTROL_ILLEGAL_OP_EN to add the registered IllegalOp output.
module control
    import mips_pkg::*;
(
    input  logic clk,
    input  logic rst,
    control_if.slave bus
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

`ifdef CONTROL_ILLEGAL_OP_EN
    logic illegal_d;
    logic illegal_q;
`endif

    control_decode u_decode (
        .opcode_i  (bus.Opcode),
        .funct_i   (bus.funct),
`ifdef CONTROL_ILLEGAL_OP_EN
        .illegal_o (illegal_d),
`endif
        .ctrl_o    (ctrl_d)
    );

    // Output register; reset clears every strobe (ALUOp becomes ALU_NOP).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

`ifdef CONTROL_ILLEGAL_OP_EN
    // Illegal-encoding flag, registered in step with the strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign bus.IllegalOp = illegal_q;
`endif

    assign bus.DstReg    = ctrl_q.dst_reg;
    assign bus.ALUSrcB   = ctrl_q.alu_src_b;
    assign bus.RegWrite  = ctrl_q.reg_write;
    assign bus.MemtoReg  = ctrl_q.mem_to_reg;
    assign bus.MemWrite  = ctrl_q.mem_write;
    assign bus.Jump      = ctrl_q.jump;
    assign bus.Branch    = ctrl_q.branch;
    assign bus.shamtFlag = ctrl_q.shamt_flag;
    assign bus.JumpReg   = ctrl_q.jump_reg;
    assign bus.ALUOp     = ctrl_q.alu_op;

endmodule

// File: tb/tb_control.sv
// Directed, table-driven bench for the MIPS main control decoder.
// Output word order: {DstReg,ALUSrcB,RegWrite,MemtoReg,MemWrite,Jump,Branch,shamtFlag,JumpReg,ALUOp[5:0]}.
module tb_control;

    logic clk;
    logic rst;
    control_if bus ();

    control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic [14:0] exp;
        logic       ill;
    } vec_t;

    int errors = 0;
    int checks = 0;

    function automatic logic [14:0] w(input logic dst, input logic srcb, input logic rw,
                                      input logic m2r, input logic mw, input logic j,
                                      input logic b, input logic sh, input logic jr,
                                      input int alu);
        logic [5:0] a;
        a = alu[5:0];
        return {dst, srcb, rw, m2r, mw, j, b, sh, jr, a};
    endfunction

    function automatic logic [14:0] outs();
        return {bus.DstReg, bus.ALUSrcB, bus.RegWrite, bus.MemtoReg, bus.MemWrite,
                bus.Jump, bus.Branch, bus.shamtFlag, bus.JumpReg, bus.ALUOp};
    endfunction

    task automatic check(input string name, input logic [14:0] exp, input logic ill);
        logic [14:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
`ifdef CONTROL_ILLEGAL_OP_EN
        checks++;
        if (bus.IllegalOp !== ill) begin
            errors++;
            $display("FAIL %s IllegalOp: got %b required %b", name, bus.IllegalOp, ill);
        end
`else
        if (ill === 1'bx) $display("note: unknown illegal flag in %s", name);
`endif
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn);
        bus.Opcode = op;
        bus.funct  = fn;
    endtask

    vec_t vecs[$];
    logic [14:0] zero_w;
    logic [14:0] addi_w;
    logic [14:0] lw_w;

    initial begin
        zero_w = w(0,0,0,0,0,0,0,0,0, 0);
        addi_w = w(0,1,1,0,0,0,0,0,0, 1);
        lw_w   = w(0,1,1,1,0,0,0,0,0, 1);

        // R-type
        vecs.push_back('{"add",   6'b000000, 6'b100000, w(1,0,1,0,0,0,0,0,0, 1), 1'b0});
        vecs.push_back('{"sub",   6'b000000, 6'b100010, w(1,0,1,0,0,0,0,0,0, 3), 1'b0});
        vecs.push_back('{"xor",   6'b000000, 6'b100110, w(1,0,1,0,0,0,0,0,0, 7), 1'b0});
        vecs.push_back('{"sll",   6'b000000, 6'b000000, w(1,0,1,0,0,0,0,1,0,11), 1'b0});
        vecs.push_back('{"srlv",  6'b000000, 6'b000110, w(1,0,1,0,0,0,0,0,0,12), 1'b0});
        vecs.push_back('{"sra",   6'b000000, 6'b000011, w(1,0,1,0,0,0,0,1,0,13), 1'b0});
        vecs.push_back('{"nor",   6'b000000, 6'b100111, w(1,0,1,0,0,0,0,0,0, 8), 1'b0});
        vecs.push_back('{"sltu",  6'b000000, 6'b101011, w(1,0,1,0,0,0,0,0,0,10), 1'b0});
        vecs.push_back('{"jr",    6'b000000, 6'b001000, w(0,0,0,0,0,0,0,0,1, 0), 1'b0});
        vecs.push_back('{"badfn", 6'b000000, 6'b001001, zero_w,                  1'b1});
        // I-type (funct deliberately non-zero to show it is ignored)
        vecs.push_back('{"addi",  6'b001000, 6'b001000, addi_w,                  1'b0});
        vecs.push_back('{"addiu", 6'b001001, 6'b111111, w(0,1,1,0,0,0,0,0,0, 2), 1'b0});
        vecs.push_back('{"andi",  6'b001100, 6'b000000, w(0,1,1,0,0,0,0,0,0, 5), 1'b0});
        vecs.push_back('{"ill100000", 6'b100000, 6'b100000, zero_w,              1'b1});
        vecs.push_back('{"ori",   6'b001101, 6'b000000, w(0,1,1,0,0,0,0,0,0, 6), 1'b0});
        vecs.push_back('{"xori",  6'b001110, 6'b000000, w(0,1,1,0,0,0,0,0,0, 7), 1'b0});
        vecs.push_back('{"lui",   6'b001111, 6'b000000, w(0,1,1,0,0,0,0,0,0,14), 1'b0});
        vecs.push_back('{"ill111111", 6'b111111, 6'b000000, zero_w,              1'b1});
        vecs.push_back('{"slti",  6'b001010, 6'b000000, w(0,1,1,0,0,0,0,0,0, 9), 1'b0});
        vecs.push_back('{"sltiu", 6'b001011, 6'b000000, w(0,1,1,0,0,0,0,0,0,10), 1'b0});
        // memory / branch
        vecs.push_back('{"lw",    6'b100011, 6'b000000, lw_w,                    1'b0});
        vecs.push_back('{"ill110000", 6'b110000, 6'b100000, zero_w,              1'b1});
        vecs.push_back('{"sw",    6'b101011, 6'b000000, w(0,1,0,0,1,0,0,0,0, 1), 1'b0});
        vecs.push_back('{"beq",   6'b000100, 6'b000000, w(0,0,0,0,0,0,1,0,0, 3), 1'b0});
        vecs.push_back('{"ill000001", 6'b000001, 6'b000000, zero_w,              1'b1});
        vecs.push_back('{"bne",   6'b000101, 6'b000000, w(0,0,0,0,0,0,1,0,0,15), 1'b0});
        // jumps
        vecs.push_back('{"j",     6'b000010, 6'b000000, w(0,0,0,0,0,1,0,0,0, 0), 1'b0});
        vecs.push_back('{"ill101010", 6'b101010, 6'b101010, zero_w,              1'b1});
        vecs.push_back('{"jal",   6'b000011, 6'b000000, w(0,0,1,0,0,1,0,0,0, 0), 1'b0});

        // Reset held with addi presented: outputs stay zero across edges.
        rst = 1'b1;
        drive(6'b001000, 6'b000000);
        #1;
        check("reset_initial", zero_w, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_hold", zero_w, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_pre_edge", zero_w, 1'b0);
        @(posedge clk); #1;
        check("post_reset_addi", addi_w, 1'b0);

        // One-edge latency: new fields do not show until the next edge.
        drive(6'b100011, 6'b000000);
        #2;
        check("latency_hold", addi_w, 1'b0);
        @(posedge clk); #1;
        check("latency_lw", lw_w, 1'b0);

        // Table sweep.
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].fn);
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].exp, vecs[i].ill);
        end

        // Asynchronous reset clears outputs without waiting for an edge.
        drive(6'b100011, 6'b000000);
        @(posedge clk); #1;
        check("pre_async_lw", lw_w, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset", zero_w, 1'b0);
        @(posedge clk); #1;
        check("async_reset_hold", zero_w, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_async_lw", lw_w, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
